// File: rtl/mem_responder.sv
// mem_responder: 512 x 32 word-addressed memory slave with a level Read/Write handshake.
// Define MEM_WAIT_STATES_EN to insert two wait states (WAIT1, WAIT2) ahead of the access.
module mem_responder (
    input  logic        Clock,
    input  logic        Clear,
    input  logic [8:0]  Address,
    input  logic        Read,
    input  logic        Write,
    input  logic [31:0] Mdataout,
    output logic [31:0] Mdatain,
    output logic        Done,
    output logic        Busy,
    output logic        Err
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_ACCESS  = 3'd1;
    localparam logic [2:0] S_RESPOND = 3'd2;
`ifdef MEM_WAIT_STATES_EN
    localparam logic [2:0] S_WAIT1   = 3'd3;
    localparam logic [2:0] S_WAIT2   = 3'd4;
`endif

    logic [2:0]  state_q, state_d;
    logic [8:0]  addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        is_read_q, is_read_d;
    logic [31:0] dout_q, dout_d;
    logic        done_q, done_d;
    logic        busy_q, busy_d;
    logic        err_q, err_d;
    logic        mem_we;

    // Storage is deliberately left out of reset so contents survive Clear.
    logic [31:0] mem_q [512];

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        is_read_d = is_read_q;
        dout_d    = dout_q;
        done_d    = 1'b0;
        busy_d    = busy_q;
        err_d     = 1'b0;
        mem_we    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (Read && Write) begin
                    err_d = 1'b1;
                end else if (Read || Write) begin
                    addr_d    = Address;
                    wdata_d   = Mdataout;
                    is_read_d = Read;
                    busy_d    = 1'b1;
`ifdef MEM_WAIT_STATES_EN
                    state_d   = S_WAIT1;
`else
                    state_d   = S_ACCESS;
`endif
                end
            end
`ifdef MEM_WAIT_STATES_EN
            S_WAIT1: state_d = S_WAIT2;
            S_WAIT2: state_d = S_ACCESS;
`endif
            S_ACCESS: begin
                if (is_read_q) begin
                    dout_d = mem_q[addr_q];
                end else begin
                    mem_we = 1'b1;
                end
                done_d  = 1'b1;
                state_d = S_RESPOND;
            end
            S_RESPOND: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clock or negedge Clear) begin
        if (!Clear) begin
            state_q   <= S_IDLE;
            addr_q    <= 9'h0;
            wdata_q   <= 32'h0;
            is_read_q <= 1'b0;
            dout_q    <= 32'h0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            is_read_q <= is_read_d;
            dout_q    <= dout_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
            err_q     <= err_d;
        end
    end

    always_ff @(posedge Clock) begin
        if (mem_we && Clear) begin
            mem_q[addr_q] <= wdata_q;
        end
    end

    assign Mdatain = dout_q;
    assign Done    = done_q;
    assign Busy    = busy_q;
    assign Err     = err_q;

endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: randomized and directed bench for mem_responder,
// checked against a transaction-timeline reference model.
module tb_mem_responder;

`ifdef MEM_WAIT_STATES_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 1;
`endif

    logic        Clock;
    logic        Clear;
    logic [8:0]  Address;
    logic        Read;
    logic        Write;
    logic [31:0] Mdataout;
    logic [31:0] Mdatain;
    logic        Done;
    logic        Busy;
    logic        Err;

    mem_responder dut (
        .Clock    (Clock),
        .Clear    (Clear),
        .Address  (Address),
        .Read     (Read),
        .Write    (Write),
        .Mdataout (Mdataout),
        .Mdatain  (Mdatain),
        .Done     (Done),
        .Busy     (Busy),
        .Err      (Err)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: a request accepted at edge acc completes at acc+LAT
    // and the responder is free again from edge acc+LAT+2.
    int          e = 0;
    int          acc = -100;
    bit          m_rd;
    logic [8:0]  m_a;
    logic [31:0] m_d;
    logic [31:0] mem_m [512];
    logic [31:0] exp_dout = 32'h0;
    bit          x_done, x_busy, x_err, accepted;

    int done_cnt, busy_cnt, err_cnt, last_done_e;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        acc      = -100;
        exp_dout = 32'h0;
    endtask

    task automatic step();
        @(posedge Clock);
        e++;
        accepted = 1'b0;
        x_err    = 1'b0;
        if (e >= acc + LAT + 2) begin
            if (Read && Write) begin
                x_err = 1'b1;
            end else if (Read || Write) begin
                acc      = e;
                m_rd     = Read;
                m_a      = Address;
                m_d      = Mdataout;
                accepted = 1'b1;
            end
        end
        x_busy = (e >= acc) && (e <= acc + LAT);
        x_done = (e == acc + LAT);
        if (x_done) begin
            if (m_rd) exp_dout = mem_m[m_a];
            else mem_m[m_a] = m_d;
        end
        #1;
        check("done", 32'(Done), 32'(x_done));
        check("busy", 32'(Busy), 32'(x_busy));
        check("err", 32'(Err), 32'(x_err));
        check("mdatain", Mdatain, exp_dout);
        if (Done) begin
            done_cnt++;
            last_done_e = e;
        end
        if (Busy) busy_cnt++;
        if (Err) err_cnt++;
    endtask

    task automatic wait_idle();
        int g = 0;
        while (e + 1 < acc + LAT + 2 && g < 20) begin
            step();
            g++;
        end
    endtask

    task automatic do_access(input bit rd, input bit wr, input logic [8:0] a, input logic [31:0] d);
        int g = 0;
        Read     = rd;
        Write    = wr;
        Address  = a;
        Mdataout = d;
        do begin
            step();
            g++;
        end while (!accepted && g < 20);
        check("accept", 32'(accepted), 32'd1);
        Read  = 1'b0;
        Write = 1'b0;
        wait_idle();
    endtask

    task automatic async_reset_check(input string tag);
        #2 Clear = 1'b0;
        #1;
        check({tag, "_mdatain"}, Mdatain, 32'h0);
        check({tag, "_done"}, 32'(Done), 32'd0);
        check({tag, "_busy"}, 32'(Busy), 32'd0);
        check({tag, "_err"}, 32'(Err), 32'd0);
        model_reset();
        @(posedge Clock);
        #1 Clear = 1'b1;
    endtask

    logic [31:0] saved;
    int          d_e [$];
    logic [31:0] d_v [$];

    initial begin
        Clear    = 1'b0;
        Read     = 1'b0;
        Write    = 1'b0;
        Address  = 9'h0;
        Mdataout = 32'h0;
        #12;
        check("rst_mdatain", Mdatain, 32'h0);
        check("rst_done", 32'(Done), 32'd0);
        check("rst_busy", 32'(Busy), 32'd0);
        check("rst_err", 32'(Err), 32'd0);
        @(posedge Clock);
        #1 Clear = 1'b1;

        done_cnt = 0; busy_cnt = 0; err_cnt = 0;
        do_access(1'b0, 1'b1, 9'h010, 32'h00000022);
        repeat (2) step();
        check("w010_done_cnt", 32'(done_cnt), 32'd1);
        check("w010_busy_cnt", 32'(busy_cnt), 32'(LAT + 1));
        check("w010_mdatain", Mdatain, 32'h0);

        do_access(1'b1, 1'b0, 9'h010, 32'h0);
        check("r010_latency", 32'(last_done_e - acc), 32'(LAT));
        check("r010_data", Mdatain, 32'h00000022);

        for (int a = 0; a < 512; a++) begin
            do_access(1'b0, 1'b1, 9'(a), $urandom);
        end

        saved = mem_m[9'h020];
        done_cnt = 0; busy_cnt = 0; err_cnt = 0;
        Read = 1'b1; Write = 1'b1; Address = 9'h020; Mdataout = $urandom;
        step();
        Read = 1'b0; Write = 1'b0;
        repeat (4) step();
        check("rw_err_cnt", 32'(err_cnt), 32'd1);
        check("rw_busy_cnt", 32'(busy_cnt), 32'd0);
        check("rw_done_cnt", 32'(done_cnt), 32'd0);
        do_access(1'b1, 1'b0, 9'h020, 32'h0);
        check("rw_020_kept", Mdatain, saved);

        saved = mem_m[9'h1FF];
        Write = 1'b1; Address = 9'h007; Mdataout = 32'h4A920000;
        step();
        check("w007_accept", 32'(accepted), 32'd1);
        Address = 9'h1FF; Mdataout = 32'hDEADBEEF;
        step();
        Write = 1'b0;
        wait_idle();
        do_access(1'b1, 1'b0, 9'h007, 32'h0);
        check("w007_data", Mdatain, 32'h4A920000);
        do_access(1'b1, 1'b0, 9'h1FF, 32'h0);
        check("w1ff_kept", Mdatain, saved);

        do_access(1'b0, 1'b1, 9'h005, 32'h00000024);
        Write = 1'b1; Address = 9'h005; Mdataout = 32'h00000027;
        step();
        check("w005_accept", 32'(accepted), 32'd1);
        repeat (LAT - 1) step();
        Write = 1'b0;
        async_reset_check("abort");
        do_access(1'b1, 1'b0, 9'h005, 32'h0);
        check("abort_005_kept", Mdatain, 32'h00000024);

        Read = 1'b1; Address = 9'h1FF;
        for (int i = 0; i < 9 + LAT + 3; i++) begin
            if (i == 9) Read = 1'b0;
            step();
            if (Done) begin
                d_e.push_back(e);
                d_v.push_back(Mdatain);
            end
        end
        check("hold_done_cnt", 32'(d_e.size()), 32'((9 + LAT + 1) / (LAT + 2)));
        for (int k = 0; k < d_e.size(); k++) begin
            check("hold_value", d_v[k], mem_m[9'h1FF]);
            if (k > 0) check("hold_spacing", 32'(d_e[k] - d_e[k-1]), 32'(LAT + 2));
        end

        for (int i = 0; i < 400; i++) begin
            int r;
            r = int'($urandom_range(0, 99));
            Read     = (r < 35) || (r >= 95);
            Write    = (r >= 35 && r < 70) || (r >= 95);
            Address  = 9'($urandom_range(0, 15));
            Mdataout = $urandom;
            step();
            if ($urandom_range(0, 49) == 0) async_reset_check("rand_rst");
        end
        Read = 1'b0; Write = 1'b0;
        wait_idle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not finish, got running expected done");
        $fatal(1);
    end

endmodule
